// File: rtl/demux_route_1x4_pkg.sv
// Shared constants and helpers for the 1-to-4 routing stage.
// Lane count and destination width are fixed; DW/DEPTH defaults live here.
package demux_route_1x4_pkg;

    localparam int LANES     = 4;
    localparam int DEST_W    = 2;
    localparam int DEF_DW    = 8;
    localparam int DEF_DEPTH = 2;

    typedef logic [DEST_W-1:0] dest_t;
    typedef logic [LANES-1:0]  lane_mask_t;

    function automatic lane_mask_t dest_onehot(input dest_t sel);
        lane_mask_t mask;
        mask      = '0;
        mask[sel] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/demux_route_1x4_if.sv
// Upstream word/destination handshake plus the four per-lane output handshakes.
// slave is the routing stage; master is whoever drives it (producer and consumers).
interface demux_route_1x4_if #(
    parameter int DW = demux_route_1x4_pkg::DEF_DW
);
    import demux_route_1x4_pkg::*;

    logic [DW-1:0]       in_data;
    dest_t               in_dest;
    logic                in_valid;
    logic                in_ready;
    logic [LANES*DW-1:0] out_data;
    lane_mask_t          out_valid;
    lane_mask_t          out_ready;

    modport slave (
        input  in_data,
        input  in_dest,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport master (
        output in_data,
        output in_dest,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/demux_route_1x4_dec.sv
// Combinational 2-to-4 one-hot decoder; all zeros when en is low.
module dec_2x4_onehot
    import demux_route_1x4_pkg::*;
(
    input  logic       en,
    input  dest_t      sel,
    output lane_mask_t onehot
);

    assign onehot = en ? dest_onehot(sel) : '0;

endmodule

// File: rtl/demux_route_1x4.sv
// Registered 1-to-4 router: each accepted word lands in its lane's FWFT FIFO
// and is presented one cycle later; lanes drain independently.
module demux_route_1x4
    import demux_route_1x4_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int DEPTH = DEF_DEPTH
) (
    input logic              clk,
    input logic              rst,
    demux_route_1x4_if.slave bus
);

    localparam int              PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL_CNT = DEPTH[PTR_W:0];

    lane_mask_t          full_w;
    lane_mask_t          wr_en_w;
    lane_mask_t          out_valid_w;
    logic [LANES*DW-1:0] out_data_w;
    logic                in_ready_w;
    logic                acc_w;

    // Ready depends only on the addressed lane's registered fill level, never on in_valid.
    assign in_ready_w    = ~full_w[bus.in_dest];
    assign acc_w         = bus.in_valid & in_ready_w;
    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.out_data  = out_data_w;

    dec_2x4_onehot u_dec (
        .en     (acc_w),
        .sel    (bus.in_dest),
        .onehot (wr_en_w)
    );

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [DW-1:0]    mem_reg [DEPTH];
            logic [PTR_W-1:0] wr_ptr_reg;
            logic [PTR_W-1:0] rd_ptr_reg;
            logic [PTR_W:0]   count_reg;
            logic [PTR_W:0]   count_next;
            logic             push_w;
            logic             pop_w;

            assign push_w = wr_en_w[gi];
            assign pop_w  = out_valid_w[gi] & bus.out_ready[gi];

            always_comb begin
                count_next = count_reg;
                case ({push_w, pop_w})
                    2'b10:   count_next = count_reg + 1'b1;
                    2'b01:   count_next = count_reg - 1'b1;
                    default: count_next = count_reg;
                endcase
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                    for (int i = 0; i < DEPTH; i++) begin
                        mem_reg[i] <= '0;
                    end
                end else begin
                    if (push_w) begin
                        mem_reg[wr_ptr_reg] <= bus.in_data;
                        wr_ptr_reg          <= wr_ptr_reg + 1'b1;
                    end
                    if (pop_w) begin
                        rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    end
                    count_reg <= count_next;
                end
            end

            assign full_w[gi]               = (count_reg == FULL_CNT);
            assign out_valid_w[gi]          = (count_reg != '0);
            assign out_data_w[gi*DW +: DW]  = mem_reg[rd_ptr_reg];
        end
    endgenerate

endmodule

// File: tb/tb_demux_route_1x4.sv
// Scoreboard bench for demux_route_1x4: per-lane expected-word queues filled by the
// driver on accept, drained and compared by a negedge monitor.
module tb_demux_route_1x4;

    localparam int DW    = 8;
    localparam int DEPTH = 2;

    logic clk;
    logic rst;

    demux_route_1x4_if #(.DW(DW)) bus ();

    demux_route_1x4 #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_q [4][$];
    logic          exp_ready_snap = 1'b1;
    logic          mon_en = 1'b0;
    logic          just_reset = 1'b0;

    // Monitor: compares the presented state with the reference queues, then retires handshakes.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [3:0] exp_v;
            for (int k = 0; k < 4; k++) begin
                exp_v[k] = (exp_q[k].size() != 0);
                checks++;
                if (bus.out_valid[k] !== exp_v[k]) begin
                    errors++;
                    $display("FAIL out_valid[%0d]: got %b expected %b at %0t", k, bus.out_valid[k], exp_v[k], $time);
                end
                if (exp_v[k]) begin
                    checks++;
                    if (bus.out_data[k*DW +: DW] !== exp_q[k][0]) begin
                        errors++;
                        $display("FAIL lane%0d data: got %h expected %h at %0t", k, bus.out_data[k*DW +: DW], exp_q[k][0], $time);
                    end
                end
            end
            if (just_reset && !rst) begin
                checks++;
                if (bus.out_data !== '0) begin
                    errors++;
                    $display("FAIL reset out_data: got %h expected 0", bus.out_data);
                end
                just_reset = 1'b0;
            end
            exp_ready_snap = (exp_q[bus.in_dest].size() < DEPTH);
            checks++;
            if (bus.in_ready !== exp_ready_snap) begin
                errors++;
                $display("FAIL in_ready dest=%0d: got %b expected %b at %0t", bus.in_dest, bus.in_ready, exp_ready_snap, $time);
            end
            if (rst) begin
                for (int k = 0; k < 4; k++) exp_q[k].delete();
                just_reset = 1'b1;
            end else begin
                for (int k = 0; k < 4; k++) begin
                    if (exp_v[k] && bus.out_ready[k]) begin
                        $display("pop  lane%0d data=%h", k, exp_q[k][0]);
                        void'(exp_q[k].pop_front());
                    end
                end
            end
        end
    end

    // One clock cycle of stimulus; called at posedge+1, returns at the next posedge+1.
    task automatic step(input logic v, input logic [1:0] d, input logic [DW-1:0] w,
                        input logic [3:0] ordy, output logic acc);
        bus.in_valid  = v;
        bus.in_dest   = d;
        bus.in_data   = w;
        bus.out_ready = ordy;
        @(negedge clk);
        #1;
        acc = v && exp_ready_snap && !rst;
        if (acc) begin
            exp_q[d].push_back(w);
            $display("push lane%0d data=%h", d, w);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic [3:0] ordy);
        logic a;
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, '0, ordy, a);
    endtask

    // Holds the word until accepted, bounded by a cycle budget.
    task automatic send(input logic [1:0] d, input logic [DW-1:0] w, input logic [3:0] ordy);
        logic a;
        int   n;
        a = 1'b0;
        n = 0;
        while (!a && n < 50) begin
            step(1'b1, d, w, ordy, a);
            n++;
        end
        checks++;
        if (!a) begin
            errors++;
            $display("FAIL send timeout: lane%0d data=%h not accepted within %0d cycles", d, w, n);
        end
    endtask

    initial begin
        logic          a;
        logic          hv;
        logic [1:0]    hd;
        logic [DW-1:0] hw;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_dest   = '0;
        bus.in_data   = '0;
        bus.out_ready = '0;
        repeat (2) @(posedge clk);
        #1;
        rst        = 1'b0;
        just_reset = 1'b1;
        mon_en     = 1'b1;

        // Reset state: in_ready for every destination.
        for (int d = 0; d < 4; d++) step(1'b0, 2'(d), '0, 4'h0, a);

        // Single route.
        step(1'b1, 2'd2, 8'hA5, 4'h0, a);
        idle(2, 4'h0);
        idle(2, 4'hF);

        // Fill / backpressure on lane 1.
        step(1'b1, 2'd1, 8'h11, 4'h0, a);
        step(1'b1, 2'd1, 8'h22, 4'h0, a);
        step(1'b1, 2'd1, 8'h33, 4'h0, a);
        step(1'b0, 2'd0, 8'h00, 4'h0, a);
        send(2'd1, 8'h33, 4'b0010);
        idle(4, 4'hF);

        // Concurrent push/pop on lane 3.
        step(1'b1, 2'd3, 8'h77, 4'h0, a);
        step(1'b1, 2'd3, 8'h44, 4'b1000, a);
        idle(1, 4'h0);
        idle(2, 4'hF);

        // Interleaved lanes, all consumers ready.
        for (int i = 1; i <= 8; i++) step(1'b1, 2'((i - 1) % 4), 8'(i), 4'hF, a);
        idle(2, 4'hF);

        // Wrap-around on lane 0.
        for (int i = 0; i < 10; i++) step(1'b1, 2'd0, 8'h80 + 8'(i), 4'b0001, a);
        idle(2, 4'hF);

        // Reset mid-traffic drops buffered words.
        step(1'b1, 2'd0, 8'h5A, 4'h0, a);
        step(1'b1, 2'd2, 8'h6B, 4'h0, a);
        step(1'b1, 2'd3, 8'h7C, 4'h0, a);
        rst = 1'b1;
        step(1'b1, 2'd1, 8'h99, 4'hF, a);
        step(1'b1, 2'd1, 8'h98, 4'hF, a);
        rst = 1'b0;
        for (int d = 0; d < 4; d++) step(1'b0, 2'(d), '0, 4'h0, a);

        // Randomised traffic with random consumer stalls.
        hv = 1'b0;
        hd = '0;
        hw = '0;
        for (int i = 0; i < 400; i++) begin
            if (!hv) begin
                hv = ($urandom_range(0, 9) < 7);
                hd = 2'($urandom_range(0, 3));
                hw = 8'($urandom);
            end
            step(hv, hd, hw, 4'($urandom), a);
            if (a) hv = 1'b0;
        end
        idle(6, 4'hF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not finish, %0d errors so far", errors);
        $fatal(1, "timeout");
    end

endmodule
